// File: rtl/embcpu_nios2_qsys_0_oci_dct_pkg.sv
// Shared constants and state encoding for the OCI debug-control-trace packer.
package embcpu_nios2_qsys_0_oci_dct_pkg;

  localparam int ENTRY_W     = 2;
  localparam int MAX_ENTRIES = 15;
  localparam int COUNT_W     = 4;
  localparam int DROP_W      = 8;
  localparam int DCT_BUF_W   = ENTRY_W * MAX_ENTRIES;

  localparam logic [COUNT_W-1:0] MAX_COUNT = COUNT_W'(MAX_ENTRIES);
  localparam logic [DROP_W-1:0]  DROP_MAX  = {DROP_W{1'b1}};

  // Trace code values produced by the CPU trace logic
  localparam logic [ENTRY_W-1:0] DCT_NT   = 2'b00;
  localparam logic [ENTRY_W-1:0] DCT_TK   = 2'b01;
  localparam logic [ENTRY_W-1:0] DCT_EXC  = 2'b10;
  localparam logic [ENTRY_W-1:0] DCT_SYNC = 2'b11;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ACCUM = 2'd1,
    ST_FULL  = 2'd2
  } dct_state_e;

endpackage

// File: rtl/embcpu_nios2_qsys_0_oci_dct_frame_reg.sv
// One-deep valid/ready holding register for completed trace frames.
module embcpu_nios2_qsys_0_oci_dct_frame_reg
  import embcpu_nios2_qsys_0_oci_dct_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 load,
  input  logic [DCT_BUF_W-1:0] load_data,
  input  logic [COUNT_W-1:0]   load_count,
  input  logic                 ready,
  output logic                 valid,
  output logic [DCT_BUF_W-1:0] data,
  output logic [COUNT_W-1:0]   count,
  output logic                 free
);

  // The stage can take a new frame when empty or when its frame leaves this cycle
  assign free = !valid || ready;

  // Capture a new frame on load, otherwise retire the held one once accepted
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid <= 1'b0;
      data  <= '0;
      count <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      count <= load_count;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/embcpu_nios2_qsys_0_oci_dct_packer.sv
// Packs 2-bit trace codes into 30-bit frames and hands them to trace storage.
module embcpu_nios2_qsys_0_oci_dct_packer
  import embcpu_nios2_qsys_0_oci_dct_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 trc_on,
  input  logic                 entry_valid,
  input  logic [ENTRY_W-1:0]   entry_code,
  input  logic                 flush,
  input  logic                 frame_ready,
  input  logic                 clear_overflow,
  output logic [DCT_BUF_W-1:0] dct_buffer,
  output logic [COUNT_W-1:0]   dct_count,
  output logic                 frame_valid,
  output logic [DCT_BUF_W-1:0] frame_data,
  output logic [COUNT_W-1:0]   frame_count,
  output logic                 overflow,
  output logic [DROP_W-1:0]    drop_count
);

  dct_state_e           state, state_nxt;
  logic [DCT_BUF_W-1:0] nb, buf_nxt;
  logic [COUNT_W-1:0]   nc, cnt_nxt;
  logic                 accept, drop, load, out_free;
  logic                 flush_req, flush_pending, flush_pending_nxt;

  // Post-accept buffer view, frame load decision and next state
  always_comb begin
    accept            = entry_valid && trc_on && (state != ST_FULL);
    drop              = entry_valid && trc_on && (state == ST_FULL);
    nb                = accept ? {dct_buffer[DCT_BUF_W-ENTRY_W-1:0], entry_code} : dct_buffer;
    nc                = accept ? dct_count + COUNT_W'(1) : dct_count;
    flush_req         = flush || flush_pending;
    load              = out_free && ((nc == MAX_COUNT) || (flush_req && (nc != '0)));
    buf_nxt           = nb;
    cnt_nxt           = nc;
    flush_pending_nxt = flush_req && (nc != '0);
    state_nxt         = ST_ACCUM;
    if (load) begin
      buf_nxt           = '0;
      cnt_nxt           = '0;
      flush_pending_nxt = 1'b0;
      state_nxt         = ST_EMPTY;
    end else if (nc == '0) begin
      state_nxt = ST_EMPTY;
    end else if (nc == MAX_COUNT) begin
      state_nxt = ST_FULL;
    end
  end

  // Live buffer, entry count, pending flush and state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_EMPTY;
      dct_buffer    <= '0;
      dct_count     <= '0;
      flush_pending <= 1'b0;
    end else begin
      state         <= state_nxt;
      dct_buffer    <= buf_nxt;
      dct_count     <= cnt_nxt;
      flush_pending <= flush_pending_nxt;
    end
  end

  // Sticky overflow flag and saturating drop counter; a same-cycle drop beats a clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (clear_overflow) begin
        drop_count <= DROP_W'(1);
      end else if (drop_count != DROP_MAX) begin
        drop_count <= drop_count + DROP_W'(1);
      end
    end else if (clear_overflow) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end
  end

  embcpu_nios2_qsys_0_oci_dct_frame_reg u_frame_reg (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (load),
    .load_data  (nb),
    .load_count (nc),
    .ready      (frame_ready),
    .valid      (frame_valid),
    .data       (frame_data),
    .count      (frame_count),
    .free       (out_free)
  );

endmodule
